// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Purpose  : AXI4-Lite slave register file with byte strobes, read-only
//            status slots, OKAY/SLVERR responses and per-register write pulses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                   ADDR_W  = 8,
    parameter int                   DATA_W  = 32,
    parameter int                   REG_NUM = 16,
    parameter logic [REG_NUM-1:0]   RO_MASK = '0,
    parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [ADDR_W-1:0]           awaddr,
    input  logic [2:0]                  awprot,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W/8-1:0]         wstrb,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [ADDR_W-1:0]           araddr,
    input  logic [2:0]                  arprot,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [DATA_W-1:0]           rdata,
    output logic [1:0]                  rresp,
    output logic [REG_NUM*DATA_W-1:0]   reg_out,
    input  logic [REG_NUM*DATA_W-1:0]   reg_in,
    output logic [REG_NUM-1:0]          wr_pulse
);

    localparam int          c_strb_w     = DATA_W / 8;
    localparam int          c_off_w      = $clog2(c_strb_w);
    localparam int          c_idx_w      = ADDR_W - c_off_w;
    localparam logic [1:0]  c_resp_okay  = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic                   rdy_en_q;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic [c_idx_w-1:0]     aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [c_strb_w-1:0]    wstrb_q, wstrb_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [REG_NUM-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]      regs_q [REG_NUM];
    logic [DATA_W-1:0]      regs_d [REG_NUM];
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_hit_rw;
    logic [c_idx_w-1:0]     w_cmt_idx, w_ar_idx;
    logic [DATA_W-1:0]      w_cmt_data;
    logic [c_strb_w-1:0]    w_cmt_strb;
    logic                   w_unused;

    // Readies depend only on internal state; rdy_en_q keeps them low through reset.
    assign awready  = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign wready   = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign bvalid   = (w_state_q == W_RESP);
    assign bresp    = bresp_q;
    assign arready  = rdy_en_q && (r_state_q == R_IDLE);
    assign rvalid   = (r_state_q == R_RESP);
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign wr_pulse = wr_pulse_q;

    assign w_aw_hs    = awvalid && awready;
    assign w_w_hs     = wvalid && wready;
    assign w_ar_hs    = arvalid && arready;
    // A beat is usable if held from earlier or handshaking right now.
    assign w_commit   = (w_state_q == W_IDLE) && (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);
    assign w_cmt_idx  = aw_held_q ? aw_idx_q : awaddr[ADDR_W-1:c_off_w];
    assign w_cmt_data = w_held_q ? wdata_q : wdata;
    assign w_cmt_strb = w_held_q ? wstrb_q : wstrb;
    assign w_ar_idx   = araddr[ADDR_W-1:c_off_w];

    // Protection bits, byte offsets and RW-slot status inputs carry no meaning here.
    assign w_unused = ^{awprot, arprot, awaddr[c_off_w-1:0], araddr[c_off_w-1:0], reg_in};

    // RO slots present zero on the register bus; the datapath reads reg_in directly.
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg_out
        assign reg_out[gi*DATA_W +: DATA_W] = RO_MASK[gi] ? '0 : regs_q[gi];
    end

    // Write path: collect AW/W beats in any order, commit once both are present.
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        w_hit_rw   = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (w_cmt_idx == c_idx_w'(i) && !RO_MASK[i]) begin
                w_hit_rw = 1'b1;
            end
        end
        case (w_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = awaddr[ADDR_W-1:c_off_w];
                end
                if (w_w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (w_commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = w_hit_rw ? c_resp_okay : c_resp_slverr;
                    for (int i = 0; i < REG_NUM; i++) begin
                        if (w_cmt_idx == c_idx_w'(i) && !RO_MASK[i]) begin
                            for (int b = 0; b < c_strb_w; b++) begin
                                if (w_cmt_strb[b]) begin
                                    regs_d[i][b*8 +: 8] = w_cmt_data[b*8 +: 8];
                                end
                            end
                            wr_pulse_d[i] = |w_cmt_strb;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: sample data on AR handshake (pre-write register values), hold until rready.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rdata_d   = '0;
                    rresp_d   = c_resp_slverr;
                    r_state_d = R_RESP;
                    for (int i = 0; i < REG_NUM; i++) begin
                        if (w_ar_idx == c_idx_w'(i)) begin
                            rresp_d = c_resp_okay;
                            rdata_d = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
                        end
                    end
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            rdy_en_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            rdy_en_q   <= 1'b1;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Purpose  : Self-checking bench for axi_lite_regfile: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int          ADDR_W  = 8;
    localparam int          DATA_W  = 32;
    localparam int          REG_NUM = 16;
    localparam logic [15:0] RO_MASK = 16'h0008;
    localparam logic [31:0] RST_VAL = 32'hC0DE_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [7:0]     awaddr = '0, araddr = '0;
    logic [2:0]     awprot = '0, arprot = '0;
    logic [31:0]    wdata = '0;
    logic [3:0]     wstrb = '0;
    logic [1:0]     bresp, rresp;
    logic [31:0]    rdata;
    logic [511:0]   reg_out;
    logic [511:0]   reg_in = '0;
    logic [15:0]    wr_pulse;

    int checks = 0;
    int errors = 0;

    logic [15:0]    ro_v = RO_MASK;

    // Behavioural model state, advanced once per clock edge.
    bit             m_en, m_aw_held, m_w_held, m_bvalid, m_rvalid;
    int             m_aw_idx;
    logic [31:0]    m_wdata, m_rdata;
    logic [3:0]     m_wstrb;
    logic [1:0]     m_bresp, m_rresp;
    logic [15:0]    m_pulse;
    logic [31:0]    m_regs [16];

    axi_lite_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM),
        .RO_MASK(RO_MASK), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_en = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
        m_aw_idx = 0; m_wdata = '0; m_wstrb = '0; m_bresp = '0; m_pulse = '0;
        m_rdata = '0; m_rresp = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = RST_VAL;
    endtask

    task automatic compare_cycle();
        chk("awready", awready, m_en && !m_bvalid && !m_aw_held);
        chk("wready",  wready,  m_en && !m_bvalid && !m_w_held);
        chk("arready", arready, m_en && !m_rvalid);
        chk("bvalid",  bvalid,  m_bvalid);
        chk("bresp",   bresp,   m_bresp);
        chk("rvalid",  rvalid,  m_rvalid);
        chk("rdata",   rdata,   m_rdata);
        chk("rresp",   rresp,   m_rresp);
        chk("wr_pulse", wr_pulse, m_pulse);
        for (int i = 0; i < 16; i++)
            chk($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32], ro_v[i] ? 32'h0 : m_regs[i]);
    endtask

    // Predict the effect of the coming edge from the inputs currently applied.
    task automatic model_step();
        bit aw_rdy, w_rdy, ar_rdy;
        int ai;
        aw_rdy = m_en && !m_bvalid && !m_aw_held;
        w_rdy  = m_en && !m_bvalid && !m_w_held;
        ar_rdy = m_en && !m_rvalid;
        m_pulse = '0;
        // read first so a same-edge write is not visible
        if (m_rvalid) begin
            if (rready) m_rvalid = 0;
        end else if (arvalid && ar_rdy) begin
            ai = int'(araddr) / 4;
            if (ai < REG_NUM) begin
                m_rdata = ro_v[ai] ? reg_in[ai*32 +: 32] : m_regs[ai];
                m_rresp = 2'b00;
            end else begin
                m_rdata = '0;
                m_rresp = 2'b10;
            end
            m_rvalid = 1;
        end
        if (m_bvalid) begin
            if (bready) m_bvalid = 0;
        end else begin
            if (awvalid && aw_rdy) begin m_aw_held = 1; m_aw_idx = int'(awaddr) / 4; end
            if (wvalid && w_rdy)   begin m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb; end
            if (m_aw_held && m_w_held) begin
                if (m_aw_idx < REG_NUM && !ro_v[m_aw_idx]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_regs[m_aw_idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                    m_pulse[m_aw_idx] = (m_wstrb != 0);
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_aw_held = 0;
                m_w_held  = 0;
                m_bvalid  = 1;
            end
        end
        m_en = 1;
        if (rst) model_reset();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            compare_cycle();
            model_step();
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int stall,
                             output logic [1:0] resp, output logic [15:0] pulse);
        bit aw_done = 0, w_done = 0, af, wf, got = 0;
        int c = 0;
        resp = '0; pulse = '0; bready = 0;
        while (!(aw_done && w_done) && c < 40) begin
            if (!aw_done && c >= aw_dly) begin awvalid = 1; awaddr = a; end
            if (!w_done && c >= w_dly) begin wvalid = 1; wdata = d; wstrb = s; end
            @(negedge clk);
            af = awvalid && awready;
            wf = wvalid && wready;
            tick();
            if (af) begin awvalid = 0; aw_done = 1; end
            if (wf) begin wvalid = 0; w_done = 1; end
            c++;
        end
        if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
        c = 0;
        while (!got && c < 40) begin
            bready = (c >= stall);
            @(negedge clk);
            if (c == 0) pulse = wr_pulse;
            if (bvalid && bready) begin resp = bresp; got = 1; end
            tick();
            c++;
        end
        bready = 0;
        if (!got) chk("write_response_timeout", 0, 1);
    endtask

    task automatic axi_read(input logic [7:0] a, input int stall,
                            output logic [31:0] d, output logic [1:0] resp);
        bit done = 0, af, got = 0;
        int c = 0;
        d = '0; resp = '0; rready = 0;
        arvalid = 1; araddr = a;
        while (!done && c < 40) begin
            @(negedge clk);
            af = arvalid && arready;
            tick();
            if (af) begin arvalid = 0; done = 1; end
            c++;
        end
        if (!done) chk("read_handshake_timeout", 0, 1);
        c = 0;
        while (!got && c < 40) begin
            rready = (c >= stall);
            @(negedge clk);
            if (rvalid && rready) begin d = rdata; resp = rresp; got = 1; end
            tick();
            c++;
        end
        rready = 0;
        if (!got) chk("read_response_timeout", 0, 1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [15:0] pulse;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) reg_in[i*32 +: 32] = $urandom;
        reg_in[3*32 +: 32] = 32'h1234_5678;
        @(posedge clk);
        #1;
        model_reset();
        fork
            monitor();
        join_none
        tick(); tick();
        rst = 0;
        tick(); tick();
        chk("reset_reg1", reg_out[1*32 +: 32], RST_VAL);

        // same-cycle AW/W
        axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, pulse);
        chk("wr1_bresp", resp, 2'b00);
        chk("wr1_pulse", pulse, 16'h0002);
        chk("wr1_reg1", reg_out[1*32 +: 32], 32'hDEAD_BEEF);
        axi_read(8'h04, 0, d, resp);
        chk("rd1_data", d, 32'hDEAD_BEEF);
        chk("rd1_resp", resp, 2'b00);

        // W first, AW three cycles later
        axi_write(8'h08, 32'h0000_00AA, 4'h1, 3, 0, 0, resp, pulse);
        chk("wr2_reg2", reg_out[2*32 +: 32], 32'hC0DE_00AA);
        chk("wr2_pulse", pulse, 16'h0004);

        // out of range
        axi_write(8'h40, 32'h1111_1111, 4'hF, 0, 0, 0, resp, pulse);
        chk("oor_bresp", resp, 2'b10);
        chk("oor_pulse", pulse, 16'h0000);
        axi_read(8'h40, 0, d, resp);
        chk("oor_rdata", d, 32'h0);
        chk("oor_rresp", resp, 2'b10);

        // read-only slot
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, pulse);
        chk("ro_bresp", resp, 2'b10);
        chk("ro_pulse", pulse, 16'h0000);
        axi_read(8'h0D, 0, d, resp);
        chk("ro_rdata", d, 32'h1234_5678);
        chk("ro_rresp", resp, 2'b00);

        // zero strobe: OKAY, nothing changes
        axi_write(8'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, resp, pulse);
        chk("zstrb_bresp", resp, 2'b00);
        chk("zstrb_pulse", pulse, 16'h0000);
        chk("zstrb_reg4", reg_out[4*32 +: 32], RST_VAL);

        // back-pressure on both response channels
        axi_write(8'h18, 32'h0BAD_F00D, 4'hC, 1, 0, 5, resp, pulse);
        chk("stall_reg6", reg_out[6*32 +: 32], 32'h0BAD_0000);
        axi_read(8'h18, 5, d, resp);
        chk("stall_rdata", d, 32'h0BAD_0000);

        // reset while a response is pending and another AW is presented
        bready = 0; awvalid = 1; awaddr = 8'h14; wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        tick();
        wvalid = 0; awaddr = 8'h1C;
        tick(); tick();
        chk("pre_rst_bvalid", bvalid, 1'b1);
        rst = 1;
        tick(); tick();
        rst = 0; awvalid = 0;
        chk("post_rst_bvalid", bvalid, 1'b0);
        chk("post_rst_reg5", reg_out[5*32 +: 32], RST_VAL);
        chk("post_rst_reg1", reg_out[1*32 +: 32], RST_VAL);
        tick();
        axi_write(8'h1C, 32'h7777_8888, 4'hF, 0, 0, 0, resp, pulse);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_reg7", reg_out[7*32 +: 32], 32'h7777_8888);

        // randomized traffic, checked cycle by cycle by the monitor
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            awvalid = $urandom_range(0, 1) == 1;
            awaddr  = 8'($urandom_range(0, 79));
            wvalid  = $urandom_range(0, 1) == 1;
            wdata   = $urandom;
            wstrb   = 4'($urandom);
            bready  = $urandom_range(0, 2) != 0;
            arvalid = $urandom_range(0, 1) == 1;
            araddr  = 8'($urandom_range(0, 79));
            rready  = $urandom_range(0, 2) != 0;
            awprot  = 3'($urandom);
            arprot  = 3'($urandom);
            if ($urandom_range(0, 49) == 0) reg_in[3*32 +: 32] = $urandom;
            tick();
        end
        rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
